// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared types and constants for the Wishbone-to-ram512x8 byte serialiser.
//   state_t        : controller FSM states
//   BYTES_PER_WORD : RAM byte accesses per bus word
//   LAT_CYCLES     : edges from request acceptance to ack assertion
//   lane_mask()    : expands a 4-bit byte select into a 32-bit data mask
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LAT_CYCLES     = 5;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_ram512x8_ctrl.sv
// wb_ram512x8_ctrl
// Wishbone-classic 32-bit slave that serialises each word access into four
// little-endian byte accesses on a 512x8 single-port synchronous SRAM.
//
// state | meaning
// IDLE  | waiting for cyc&stb; RAM address parked at {adr_q,2'b00}
// ISSUE | one RAM byte access per cycle, cnt = 0..3
// DRAIN | last read byte arrives from the RAM; ack/data registered
// ACK   | wb_ack_o high for this single cycle
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i    bus cycle / strobe
//   wb_we_i               1 = write
//   wb_adr_i [WB_AW]      word address
//   wb_sel_i [4]          byte-lane enables
//   wb_dat_i [32]         write data
//   wb_dat_o [32]         read data, valid with wb_ack_o
//   wb_ack_o              single-cycle acknowledge
//   ram_wen_o             RAM write enable
//   ram_adr_o [RAM_AW]    RAM byte address
//   ram_dat_o [8]         RAM write data
//   ram_dat_i [8]         RAM read data, one cycle after address
module wb_ram512x8_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int RAM_AW     = 9,
  parameter bit ZERO_UNSEL = 1'b0,
  localparam int WB_AW     = RAM_AW - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [WB_AW-1:0]  wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              ram_wen_o,
  output logic [RAM_AW-1:0] ram_adr_o,
  output logic [7:0]        ram_dat_o,
  input  logic [7:0]        ram_dat_i
);

  state_t           state;
  logic [1:0]       cnt;
  logic [WB_AW-1:0] adr_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [31:0]      dat_q;
  logic [23:0]      rd_q;

  logic [1:0]  cnt_inc;
  logic [31:0] word_rd;

  assign cnt_inc = cnt + 2'd1;
  // Lane 3 is still on ram_dat_i in DRAIN, so it is taken straight from the pin.
  assign word_rd = {ram_dat_i, rd_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      dat_q     <= 32'h0;
      rd_q      <= 24'h0;
      wb_dat_o  <= 32'h0;
      wb_ack_o  <= 1'b0;
      ram_wen_o <= 1'b0;
      ram_adr_o <= '0;
      ram_dat_o <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          ram_wen_o <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            adr_q     <= wb_adr_i;
            we_q      <= wb_we_i;
            sel_q     <= wb_sel_i;
            dat_q     <= wb_dat_i;
            cnt       <= 2'd0;
            state     <= ISSUE;
            // Outputs are registered, so byte 0 is launched from the bus inputs.
            ram_adr_o <= {wb_adr_i, 2'b00};
            ram_dat_o <= wb_dat_i[7:0];
            ram_wen_o <= wb_we_i & wb_sel_i[0];
          end
        end

        ISSUE: begin
          if (!wb_cyc_i) begin
            state     <= IDLE;
            ram_wen_o <= 1'b0;
            ram_adr_o <= {adr_q, 2'b00};
          end else begin
            // Read data lags the address by one cycle: byte cnt-1 is on the pins.
            case (cnt)
              2'd1:    rd_q[7:0]   <= ram_dat_i;
              2'd2:    rd_q[15:8]  <= ram_dat_i;
              2'd3:    rd_q[23:16] <= ram_dat_i;
              default: ;
            endcase
            cnt <= cnt_inc;
            if (cnt == 2'd3) begin
              state     <= DRAIN;
              ram_wen_o <= 1'b0;
            end else begin
              ram_adr_o <= {adr_q, cnt_inc};
              ram_dat_o <= dat_q[{cnt_inc, 3'b000} +: 8];
              ram_wen_o <= we_q & sel_q[cnt_inc];
            end
          end
        end

        DRAIN: begin
          ram_wen_o <= 1'b0;
          if (!wb_cyc_i) begin
            state     <= IDLE;
            ram_adr_o <= {adr_q, 2'b00};
          end else begin
            wb_ack_o <= 1'b1;
            state    <= ACK;
            if (!we_q) begin
              wb_dat_o <= ZERO_UNSEL ? (word_rd & lane_mask(sel_q)) : word_rd;
            end
          end
        end

        ACK: begin
          wb_ack_o  <= 1'b0;
          ram_wen_o <= 1'b0;
          ram_adr_o <= {adr_q, 2'b00};
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          wb_ack_o  <= 1'b0;
          ram_wen_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram512x8_ctrl.sv
// tb_wb_ram512x8_ctrl
// Directed bench for wb_ram512x8_ctrl (ZERO_UNSEL=1) with a behavioural
// 512x8 synchronous-read RAM attached to the RAM port.
module tb_wb_ram512x8_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [6:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        ram_wen;
  logic [8:0]  ram_adr;
  logic [7:0]  ram_wd;
  logic [7:0]  ram_rd;
  logic        mem_init;

  logic [7:0]  mem [0:511];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_ram512x8_ctrl #(.RAM_AW(9), .ZERO_UNSEL(1'b1)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (dat_w),
    .wb_dat_o (dat_r),
    .wb_ack_o (ack),
    .ram_wen_o(ram_wen),
    .ram_adr_o(ram_adr),
    .ram_dat_o(ram_wd),
    .ram_dat_i(ram_rd)
  );

  // RAM model: write on edge, registered read (old data on a same-cycle write).
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[9'h1FC] <= 8'h11;
      mem[9'h1FD] <= 8'h22;
      mem[9'h1FE] <= 8'h33;
      mem[9'h1FF] <= 8'h44;
      ram_rd <= 8'h00;
    end else begin
      if (ram_wen) mem[ram_adr] <= ram_wd;
      ram_rd <= mem[ram_adr];
    end
  end

  function automatic logic [31:0] mem_word(input logic [6:0] a);
    mem_word = {mem[{a, 2'd3}], mem[{a, 2'd2}], mem[{a, 2'd1}], mem[{a, 2'd0}]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full bus access; records ack latency (negedges after the accepting
  // edge), ack length, lanes written, and read data sampled during ack.
  task automatic access(input logic w, input logic [6:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output int lat, output int ack_len, output logic [3:0] wmask);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    @(posedge clk);
    lat = 0; ack_len = 0; wmask = 4'h0; rdata = 32'h0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ram_wen) wmask[ram_adr[1:0]] = 1'b1;
      if (ack) begin
        if (ack_len == 0) begin
          lat   = i;
          rdata = dat_r;
          cyc   = 1'b0;
          stb   = 1'b0;
        end
        ack_len++;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] rdata;
    int          lat, ack_len, ack_seen, wen_seen;
    logic [3:0]  wmask;

    rst = 1'b1; mem_init = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 7'h0; sel = 4'h0; dat_w = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    check("reset_ack", {31'h0, ack}, 32'h0);
    check("reset_dat_o", dat_r, 32'h0);
    check("reset_wen", {31'h0, ram_wen}, 32'h0);
    check("reset_ram_adr", {23'h0, ram_adr}, 32'h0);
    check("reset_ram_dat", {24'h0, ram_wd}, 32'h0);

    // Full write
    access(1'b1, 7'h05, 4'hF, 32'hDEADBEEF, rdata, lat, ack_len, wmask);
    check("wr_latency", lat, 6);
    check("wr_ack_len", ack_len, 1);
    check("wr_lanes", {28'h0, wmask}, 32'hF);
    check("wr_mem", mem_word(7'h05), 32'hDEADBEEF);
    check("wr_dat_o_hold", dat_r, 32'h0);

    // Full read
    access(1'b0, 7'h05, 4'hF, 32'h0, rdata, lat, ack_len, wmask);
    check("rd_data", rdata, 32'hDEADBEEF);
    check("rd_latency", lat, 6);
    check("rd_ack_len", ack_len, 1);
    check("rd_no_wen", {28'h0, wmask}, 32'h0);
    check("rd_dat_o_hold", dat_r, 32'hDEADBEEF);

    // Masked read with unselected lanes zeroed
    access(1'b0, 7'h05, 4'b0011, 32'h0, rdata, lat, ack_len, wmask);
    check("rd_masked", rdata, 32'h0000BEEF);

    // Partial write lanes 0 and 2; write ack carries the last read word
    access(1'b1, 7'h05, 4'b0101, 32'h11223344, rdata, lat, ack_len, wmask);
    check("pwr_lanes", {28'h0, wmask}, 32'h5);
    check("pwr_ack_data", rdata, 32'h0000BEEF);
    check("pwr_latency", lat, 6);
    access(1'b0, 7'h05, 4'hF, 32'h0, rdata, lat, ack_len, wmask);
    check("pwr_readback", rdata, 32'hDE22BE44);

    // Abort: cyc low when cnt would advance to 2
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h10; sel = 4'hF; dat_w = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_cnt1_adr", {23'h0, ram_adr}, 32'h41);
    cyc = 1'b0; stb = 1'b0;
    ack_seen = 0; wen_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) ack_seen++;
      if (ram_wen) wen_seen++;
    end
    check("abort_no_ack", ack_seen, 0);
    check("abort_no_wen", wen_seen, 0);
    check("abort_mem", mem_word(7'h10), 32'h0000F00D);
    access(1'b0, 7'h10, 4'hF, 32'h0, rdata, lat, ack_len, wmask);
    check("abort_next_rd", rdata, 32'h0000F00D);
    check("abort_next_lat", lat, 6);

    // Reset during ISSUE cnt=1
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'h20; sel = 4'hF; dat_w = 32'h99999999;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_cnt1_wen", {31'h0, ram_wen}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("rst_mid_wen", {31'h0, ram_wen}, 32'h0);
    check("rst_mid_ack", {31'h0, ack}, 32'h0);
    check("rst_mid_adr", {23'h0, ram_adr}, 32'h0);
    check("rst_mid_dat_o", dat_r, 32'h0);
    ack_seen = 0; wen_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) ack_seen++;
      if (ram_wen) wen_seen++;
    end
    check("rst_no_ack", ack_seen, 0);
    check("rst_no_wen", wen_seen, 0);
    check("rst_mem", mem_word(7'h20), 32'h00009999);

    // Top word after reset
    access(1'b0, 7'h7F, 4'hF, 32'h0, rdata, lat, ack_len, wmask);
    check("top_rd", rdata, 32'h44332211);
    check("top_latency", lat, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
